nibble_serial_adder: RTL

//  Adds two WIDTH-bit operands by streaming them one nibble per cycle

---
 rtl/nibble_serial_adder.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
//   Adds two WIDTH-bit operands (WIDTH = 4*NIBBLES) by streaming them one
//   nibble per cycle through a single ripple_carry_adder_4_bit instance. The
//   carry between nibbles is held in a register. Both sides use a valid/ready
//   handshake.
//
//   Optional feature macro: SUBTRACT_EN
//     Defined   -> adds input `sub`; when sub=1 the block computes a - b
//                  (effective B = ~b, carry into nibble 0 forced to 1,
//                  carry_in ignored). carry_out=1 means "no borrow".
//     Undefined -> always a + b + carry_in.
//
//   Ports
//     clk        in   1      rising-edge clock
//     reset      in   1      asynchronous, active-high reset
//     in_valid   in   1      operands / carry_in valid
//     in_ready   out  1      block can accept operands (registered)
//     a, b       in   WIDTH  operands
//     carry_in   in   1      carry into nibble 0
//     sub        in   1      subtract select (SUBTRACT_EN only)
//     out_valid  out  1      result valid (registered)
//     out_ready  in   1      consumer accepts result
//     sum        out  WIDTH  result, modulo 2^WIDTH
//     carry_out  out  1      carry out of the top nibble
//     overflow   out  1      two's-complement overflow of the add
//
//   Timing: out_valid rises NIBBLES cycles after the accepting edge; the
//   result holds until out_ready, then the block returns to IDLE.
// ---------------------------------------------------------------------------

// 4-bit ripple-carry adder: the only arithmetic element in the datapath.
module ripple_carry_adder_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] out,
  output logic       carry_out
);

  logic [4:0] carry_s;

  assign carry_s[0] = carry_in;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign out[i]       = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end

  assign carry_out = carry_s[4];

endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 carry_in,
`ifdef SUBTRACT_EN
  input  logic                 sub,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 carry_out,
  output logic                 overflow
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;          // effective B (already inverted for subtract)
  logic               carry_q;      // carry between nibbles
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_out_q;
  logic               overflow_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [WIDTH-1:0]   b_eff_s;
  logic               cin_eff_s;
  logic [3:0]         nib_a_s;
  logic [3:0]         nib_b_s;
  logic [3:0]         nib_sum_d;
  logic               nib_carry_d;
  logic               last_nibble_s;
  logic               overflow_d;

  // Effective operand B and initial carry, selected before they are latched.
  always_comb begin
    b_eff_s   = b;
    cin_eff_s = carry_in;
`ifdef SUBTRACT_EN
    if (sub) begin
      b_eff_s   = ~b;
      cin_eff_s = 1'b1;
    end else begin
      b_eff_s   = b;
      cin_eff_s = carry_in;
    end
`endif
  end

  // Slice the current nibble of each stored operand for the adder.
  always_comb begin
    nib_a_s       = a_q[4*idx_q +: 4];
    nib_b_s       = b_q[4*idx_q +: 4];
    last_nibble_s = (idx_q == IDX_W'(NIBBLES - 1));
    // Overflow uses the effective B; nib_sum_d[3] is the result MSB on the last nibble.
    overflow_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (nib_sum_d[3] != a_q[WIDTH-1]);
  end

  ripple_carry_adder_4_bit u_rca (
    .a         (nib_a_s),
    .b         (nib_b_s),
    .carry_in  (carry_q),
    .out       (nib_sum_d),
    .carry_out (nib_carry_d)
  );

  // Control FSM and datapath registers, all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      idx_q       <= {IDX_W{1'b0}};
      sum_q       <= {WIDTH{1'b0}};
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b_eff_s;
            carry_q    <= cin_eff_s;
            idx_q      <= {IDX_W{1'b0}};
            sum_q      <= {WIDTH{1'b0}};
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
          end else begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        S_RUN: begin
          sum_q[4*idx_q +: 4] <= nib_sum_d;
          carry_q             <= nib_carry_d;
          idx_q               <= idx_q + IDX_W'(1);
          if (last_nibble_s) begin
            carry_out_q <= nib_carry_d;
            overflow_q  <= overflow_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            state_q     <= S_RUN;
          end
        end
        S_DONE: begin
          // Return to IDLE only; a new operand is never accepted on this edge.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b0;
            state_q     <= S_DONE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule
